// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: stopwatch control FSM with a BCD mm:ss.cc counter and a lap snapshot.
//
// Ports:
//   clk          sole clock; all state changes on its rising edge
//   reset        synchronous, active-low reset
//   tick         one-cycle 10 ms pulse from the external 10 ms timer
//   start_stop   one-cycle pulse: start, or pause
//   lap          one-cycle pulse: freeze, or release, the display
//   clear        one-cycle pulse: zero the count (only acts in PAUSE)
//   timer_reset  active-high reset to the 10 ms timer (high in IDLE and PAUSE)
//   running      high in RUN or LAP
//   lap_active   high in LAP
//   disp_cs      displayed centiseconds, 2 BCD digits
//   disp_sec     displayed seconds, 2 BCD digits
//   disp_min     displayed minutes, 2 BCD digits
//   overflow     one-cycle pulse when the count wraps from MAX_MIN:59.99 to 00:00.00
module stopwatch_ctrl #(
    parameter logic [7:0] MAX_MIN = 8'h59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clear,
    output logic       timer_reset,
    output logic       running,
    output logic       lap_active,
    output logic [7:0] disp_cs,
    output logic [7:0] disp_sec,
    output logic [7:0] disp_min,
    output logic       overflow
);

    typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_t;

    state_t     state;
    logic [7:0] cs, sec, min;
    logic [7:0] snap_cs, snap_sec, snap_min;
    logic [7:0] cs_n, sec_n, min_n;
    logic       wrap;
    logic       counting;

    // Two-digit BCD increment; callers handle the wrap value themselves.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Next live count for one tick, with the carry chain cs -> sec -> min.
    always_comb begin
        cs_n  = cs;
        sec_n = sec;
        min_n = min;
        wrap  = 1'b0;
        if (cs == 8'h99) begin
            cs_n = 8'h00;
            if (sec == 8'h59) begin
                sec_n = 8'h00;
                if (min == MAX_MIN) begin
                    min_n = 8'h00;
                    wrap  = 1'b1;
                end else begin
                    min_n = bcd_inc(min);
                end
            end else begin
                sec_n = bcd_inc(sec);
            end
        end else begin
            cs_n = bcd_inc(cs);
        end
    end

    // Counting is decided by the state before this edge's transition.
    assign counting = tick && (state == RUN || state == LAP);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cs       <= 8'h00;
            sec      <= 8'h00;
            min      <= 8'h00;
            snap_cs  <= 8'h00;
            snap_sec <= 8'h00;
            snap_min <= 8'h00;
            overflow <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (counting) begin
                cs       <= cs_n;
                sec      <= sec_n;
                min      <= min_n;
                overflow <= wrap;
            end

            // Strict priority: the highest asserted pulse is the only one
            // considered, even when it has no effect in the current state.
            if (clear) begin
                if (state == PAUSE) begin
                    state    <= IDLE;
                    cs       <= 8'h00;
                    sec      <= 8'h00;
                    min      <= 8'h00;
                    snap_cs  <= 8'h00;
                    snap_sec <= 8'h00;
                    snap_min <= 8'h00;
                end
            end else if (start_stop) begin
                case (state)
                    IDLE:    state <= RUN;
                    RUN:     state <= PAUSE;
                    LAP:     state <= PAUSE;
                    PAUSE:   state <= RUN;
                    default: state <= IDLE;
                endcase
            end else if (lap) begin
                if (state == RUN) begin
                    state    <= LAP;
                    // Snapshot takes the pre-tick value of this edge.
                    snap_cs  <= cs;
                    snap_sec <= sec;
                    snap_min <= min;
                end else if (state == LAP) begin
                    state <= RUN;
                end
            end
        end
    end

    assign timer_reset = (state == IDLE) || (state == PAUSE);
    assign running     = (state == RUN) || (state == LAP);
    assign lap_active  = (state == LAP);
    assign disp_cs     = lap_active ? snap_cs  : cs;
    assign disp_sec    = lap_active ? snap_sec : sec;
    assign disp_min    = lap_active ? snap_min : min;

endmodule
